// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcodes, ALU op encoding and control words shared by the decode stage
package decode_pkg;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_ADDI = 7'b0010011;
    localparam logic [6:0] OPC_LD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_SD   = 7'b0100011;
    localparam logic [6:0] OPC_B    = 7'b1100011;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLL = 3'b100,
        ALU_SLT = 3'b101
    } alu_op_e;

    localparam int CTRL_WB_W = 2;
    localparam int CTRL_M_W  = 2;
    localparam int CTRL_EX_W = 4;

    // wb = {MemtoReg, RegWrite}, m = {MemRead, MemWrite}, ex = {ALUSrc, ALUOp}
    typedef struct packed {
        logic [CTRL_WB_W-1:0] wb;
        logic [CTRL_M_W-1:0]  m;
        logic [CTRL_EX_W-1:0] ex;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE   = 8'b00_00_0000;
    localparam ctrl_t CTRL_ADDI   = 8'b01_00_1000;
    localparam ctrl_t CTRL_LD     = 8'b11_10_1000;
    localparam ctrl_t CTRL_SD     = 8'b00_01_1000;
    localparam ctrl_t CTRL_R_BASE = 8'b01_00_0000;
    localparam ctrl_t CTRL_B      = 8'b00_00_0001;
    localparam ctrl_t CTRL_JUMP   = 8'b01_00_0000;

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2-read/1-write register file with x0 hardwired and writeback bypass
module reg_file #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    // A same-cycle write is forwarded so the reader sees the value being retired now.
    assign rdata1 = (raddr1 == '0) ? '0 :
                    (we && waddr == raddr1) ? wdata : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 :
                    (we && waddr == raddr2) ? wdata : regs[raddr2];

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode, register read, load-use stall and ID/EX register
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_instr,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rdata1,
    output logic [XLEN-1:0] ex_rdata2,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_target,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic [1:0]      ex_ctrl_wb,
    output logic [1:0]      ex_ctrl_m,
    output logic [3:0]      ex_ctrl_ex,
    output logic            ex_br,
    output logic            ex_jal,
    output logic            ex_jalr,
    output logic            ex_illegal
);

    localparam int AW = $clog2(NREGS);

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] funct3;

    assign opcode = if_instr[6:0];
    assign rd     = if_instr[11:7];
    assign funct3 = if_instr[14:12];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;

    assign imm_i = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7],
                    if_instr[30:25], if_instr[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){if_instr[31]}}, if_instr[31], if_instr[19:12],
                    if_instr[20], if_instr[30:21], 1'b0};

    alu_op_e r_op;
    logic    r_legal;

    always_comb begin
        r_op    = ALU_ADD;
        r_legal = 1'b1;
        case (funct3)
            3'b000:  r_op = if_instr[30] ? ALU_SUB : ALU_ADD;
            3'b001:  r_op = ALU_SLL;
            3'b010:  r_op = ALU_SLT;
            3'b110:  r_op = ALU_OR;
            3'b111:  r_op = ALU_AND;
            default: r_legal = 1'b0;
        endcase
    end

    ctrl_t           ctrl;
    logic [XLEN-1:0] imm;
    logic            is_br;
    logic            is_jal;
    logic            is_jalr;
    logic            is_illegal;

    always_comb begin
        ctrl       = CTRL_NONE;
        imm        = '0;
        is_br      = 1'b0;
        is_jal     = 1'b0;
        is_jalr    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OPC_R: begin
                if (r_legal) begin
                    ctrl       = CTRL_R_BASE;
                    ctrl.ex[2:0] = r_op;
                end else begin
                    is_illegal = 1'b1;
                end
            end
            OPC_ADDI: begin
                ctrl = CTRL_ADDI;
                imm  = imm_i;
            end
            OPC_LD: begin
                ctrl = CTRL_LD;
                imm  = imm_i;
            end
            OPC_JALR: begin
                ctrl    = CTRL_JUMP;
                imm     = imm_i;
                is_jalr = 1'b1;
            end
            OPC_SD: begin
                ctrl = CTRL_SD;
                imm  = imm_s;
            end
            OPC_B: begin
                ctrl  = CTRL_B;
                imm   = imm_b;
                is_br = 1'b1;
            end
            OPC_JAL: begin
                ctrl   = CTRL_JUMP;
                imm    = imm_j;
                is_jal = 1'b1;
            end
            default: is_illegal = 1'b1;
        endcase
    end

    logic use_rs1;
    logic use_rs2;
    logic hazard;
    logic bubble;

    assign use_rs1 = (opcode != OPC_JAL);
    assign use_rs2 = (opcode == OPC_R) || (opcode == OPC_SD) || (opcode == OPC_B);

    // Load-use: the load in EX produces its data too late for this instruction's operands.
    assign hazard = ex_valid && ex_ctrl_m[1] && (ex_rd != 5'd0) &&
                    ((use_rs1 && ex_rd == rs1) || (use_rs2 && ex_rd == rs2));
    assign stall  = reset_n && if_valid && !flush && hazard;
    assign bubble = !if_valid || flush || stall;

    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;

    reg_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_reg_file (
        .clk    (clk),
        .reset_n(reset_n),
        .raddr1 (rs1[AW-1:0]),
        .rdata1 (rdata1),
        .raddr2 (rs2[AW-1:0]),
        .rdata2 (rdata2),
        .we     (wb_we),
        .waddr  (wb_addr[AW-1:0]),
        .wdata  (wb_data)
    );

    // A bubble clears every field, so downstream never sees stale operands.
    always_ff @(posedge clk) begin
        if (!reset_n || bubble) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_rdata1  <= '0;
            ex_rdata2  <= '0;
            ex_imm     <= '0;
            ex_target  <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_rd      <= '0;
            ex_funct3  <= '0;
            ex_ctrl_wb <= '0;
            ex_ctrl_m  <= '0;
            ex_ctrl_ex <= '0;
            ex_br      <= 1'b0;
            ex_jal     <= 1'b0;
            ex_jalr    <= 1'b0;
            ex_illegal <= 1'b0;
        end else begin
            ex_valid   <= 1'b1;
            ex_pc      <= if_pc;
            ex_rdata1  <= rdata1;
            ex_rdata2  <= rdata2;
            ex_imm     <= imm;
            ex_target  <= if_pc + imm;
            ex_rs1     <= rs1;
            ex_rs2     <= rs2;
            ex_rd      <= rd;
            ex_funct3  <= funct3;
            ex_ctrl_wb <= ctrl.wb;
            ex_ctrl_m  <= ctrl.m;
            ex_ctrl_ex <= ctrl.ex;
            ex_br      <= is_br;
            ex_jal     <= is_jal;
            ex_jalr    <= is_jalr;
            ex_illegal <= is_illegal;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - decode_stage bench: directed cases plus randomized run against a reference model
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        flush;
    logic        stall;
    logic        ex_valid;
    logic [63:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm, ex_target;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_ctrl_wb, ex_ctrl_m;
    logic [3:0]  ex_ctrl_ex;
    logic        ex_br, ex_jal, ex_jalr, ex_illegal;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(64), .NREGS(32)) dut (
        .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .stall(stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
        .ex_imm(ex_imm), .ex_target(ex_target), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_ctrl_wb(ex_ctrl_wb), .ex_ctrl_m(ex_ctrl_m),
        .ex_ctrl_ex(ex_ctrl_ex), .ex_br(ex_br), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
        .ex_illegal(ex_illegal)
    );

    typedef struct packed {
        logic        valid;
        logic [63:0] pc, rdata1, rdata2, imm, target;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [1:0]  wb, m;
        logic [3:0]  ex;
        logic        br, jal, jalr, illegal;
    } idex_t;

    idex_t dut_q;
    assign dut_q = {ex_valid, ex_pc, ex_rdata1, ex_rdata2, ex_imm, ex_target, ex_rs1, ex_rs2,
                    ex_rd, ex_funct3, ex_ctrl_wb, ex_ctrl_m, ex_ctrl_ex, ex_br, ex_jal,
                    ex_jalr, ex_illegal};

    int    checks = 0;
    int    errors = 0;
    idex_t exp_q;
    logic [63:0] mreg [32];
    logic  model_ok = 1'b0;
    logic  last_stall = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_s(input string name, input idex_t act, input idex_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    // Immediates as signed arithmetic on the scattered bit fields.
    function automatic longint imm_i(input logic [31:0] w);
        return longint'(w[30:20]) - (w[31] ? 64'sd2048 : 64'sd0);
    endfunction

    function automatic longint imm_s(input logic [31:0] w);
        return longint'(w[30:25]) * 32 + longint'(w[11:7]) - (w[31] ? 64'sd2048 : 64'sd0);
    endfunction

    function automatic longint imm_b(input logic [31:0] w);
        return longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2
               - (w[31] ? 64'sd4096 : 64'sd0);
    endfunction

    function automatic longint imm_j(input logic [31:0] w);
        return longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2
               - (w[31] ? 64'sd1048576 : 64'sd0);
    endfunction

    function automatic idex_t ref_decode(input logic [31:0] w, input logic [63:0] pc);
        idex_t  e;
        longint imm;
        e = '0;
        imm = 0;
        e.valid = 1'b1;
        e.pc = pc;
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.rd  = w[11:7];
        e.f3  = w[14:12];
        case (w[6:0])
            7'b0110011: begin
                e.wb = 2'b01;
                case (w[14:12])
                    3'b000:  e.ex = w[30] ? 4'b0001 : 4'b0000;
                    3'b001:  e.ex = 4'b0100;
                    3'b010:  e.ex = 4'b0101;
                    3'b111:  e.ex = 4'b0010;
                    3'b110:  e.ex = 4'b0011;
                    default: begin e.wb = 2'b00; e.illegal = 1'b1; end
                endcase
            end
            7'b0010011: begin imm = imm_i(w); e.wb = 2'b01; e.ex = 4'b1000; end
            7'b0000011: begin imm = imm_i(w); e.wb = 2'b11; e.m = 2'b10; e.ex = 4'b1000; end
            7'b1100111: begin imm = imm_i(w); e.wb = 2'b01; e.jalr = 1'b1; end
            7'b0100011: begin imm = imm_s(w); e.m = 2'b01; e.ex = 4'b1000; end
            7'b1100011: begin imm = imm_b(w); e.ex = 4'b0001; e.br = 1'b1; end
            7'b1101111: begin imm = imm_j(w); e.wb = 2'b01; e.jal = 1'b1; end
            default:    e.illegal = 1'b1;
        endcase
        e.imm    = 64'(imm);
        e.target = pc + 64'(imm);
        e.rdata1 = mreg[w[19:15]];
        e.rdata2 = mreg[w[24:20]];
        return e;
    endfunction

    function automatic logic ref_stall();
        logic [6:0] op;
        logic       u1, u2;
        op = if_instr[6:0];
        u1 = (op != 7'b1101111);
        u2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
        return reset_n && !flush && if_valid && exp_q.valid && exp_q.m[1] && exp_q.rd != 5'd0 &&
               ((u1 && exp_q.rd == if_instr[19:15]) || (u2 && exp_q.rd == if_instr[24:20]));
    endfunction

    // The write is applied before the operand read, which is exactly what the bypass promises.
    always @(posedge clk) begin
        logic st;
        st = ref_stall();
        last_stall = st;
        if (!reset_n) begin
            exp_q = '0;
            for (int i = 0; i < 32; i++) mreg[i] = '0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (wb_we && wb_addr != 5'd0) mreg[wb_addr] = wb_data;
            exp_q = (if_valid && !flush && !st) ? ref_decode(if_instr, if_pc) : idex_t'('0);
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check_s("idex", dut_q, exp_q);
            check("stall", 64'(stall), 64'(ref_stall()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] w);
        if_valid = v;
        if_pc    = pc;
        if_instr = w;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, r1, r2;
        logic [31:0] rnd;
        rd  = 5'($urandom_range(0, 7));
        r1  = 5'($urandom_range(0, 7));
        r2  = 5'($urandom_range(0, 7));
        rnd = $urandom;
        case ($urandom_range(0, 9))
            0:       return enc_r(7'(rnd), r2, r1, 3'($urandom), rd);
            1:       return enc_i(12'(rnd), r1, 3'b000, rd, 7'b0010011);
            2, 8, 9: return enc_i(12'(rnd), r1, 3'b011, rd, 7'b0000011);
            3:       return enc_s(12'(rnd), r2, r1, 3'b011);
            4:       return enc_b(13'(rnd), r2, r1, 3'($urandom));
            5:       return enc_j(21'(rnd), rd);
            6:       return enc_i(12'(rnd), r1, 3'b000, rd, 7'b1100111);
            default: return rnd;
        endcase
    endfunction

    localparam logic [31:0] I_LD  = 32'h0000B303;
    localparam logic [31:0] I_ADD = 32'h002303B3;

    initial begin
        reset_n = 1'b0;
        flush   = 1'b0;
        wb_we   = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        drive(1'b0, 64'h0, 32'h0);
        tick();
        tick();
        check("reset_valid", 64'(ex_valid), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_ctrl", 64'({ex_ctrl_wb, ex_ctrl_m, ex_ctrl_ex}), 64'd0);
        reset_n = 1'b1;

        check("enc_ld", 64'(enc_i(12'd0, 5'd1, 3'b011, 5'd6, 7'b0000011)), 64'(I_LD));
        check("enc_add", 64'(enc_r(7'd0, 5'd2, 5'd6, 3'b000, 5'd7)), 64'(I_ADD));

        drive(1'b1, 64'h0, enc_i(12'hFFF, 5'd0, 3'b000, 5'd5, 7'b0010011));
        tick();
        check("addi_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_ex", 64'(ex_ctrl_ex), 64'b1000);
        check("addi_wb", 64'(ex_ctrl_wb), 64'b01);

        drive(1'b1, 64'h4, I_LD);
        tick();
        drive(1'b1, 64'h8, I_ADD);
        @(negedge clk);
        check("lu_stall", 64'(stall), 64'd1);
        tick();
        check("lu_bubble", 64'(ex_valid), 64'd0);
        @(negedge clk);
        check("lu_stall_clear", 64'(stall), 64'd0);
        tick();
        check("lu_issue_valid", 64'(ex_valid), 64'd1);
        check("lu_issue_rd", 64'(ex_rd), 64'd7);

        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 64'h1234;
        drive(1'b1, 64'hC, enc_r(7'd0, 5'd0, 5'd3, 3'b000, 5'd8));
        tick();
        check("bypass_rdata1", ex_rdata1, 64'h1234);

        wb_addr = 5'd0; wb_data = 64'hDEAD;
        drive(1'b1, 64'h10, enc_r(7'd0, 5'd0, 5'd0, 3'b000, 5'd9));
        tick();
        check("x0_bypass", ex_rdata1, 64'd0);
        wb_we = 1'b0;
        tick();
        check("x0_read1", ex_rdata1, 64'd0);
        check("x0_read2", ex_rdata2, 64'd0);

        drive(1'b1, 64'h100, enc_b(13'h1FF8, 5'd2, 5'd1, 3'b000));
        tick();
        check("beq_target", ex_target, 64'hF8);
        check("beq_br", 64'(ex_br), 64'd1);
        flush = 1'b1;
        tick();
        check("beq_flush_valid", 64'(ex_valid), 64'd0);
        flush = 1'b0;

        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, enc_j(21'd8, 5'd1));
        tick();
        check("jal_wrap", ex_target, 64'h4);

        drive(1'b1, 64'h20, I_LD);
        tick();
        drive(1'b1, 64'h24, I_ADD);
        flush = 1'b1;
        @(negedge clk);
        check("flush_over_stall", 64'(stall), 64'd0);
        tick();
        check("flush_bubble", 64'(ex_valid), 64'd0);
        flush = 1'b0;

        drive(1'b1, 64'h30, I_LD);
        tick();
        drive(1'b1, 64'h34, I_ADD);
        @(negedge clk);
        check("rst_pre_stall", 64'(stall), 64'd1);
        #1 reset_n = 1'b0;
        #1 check("rst_during_stall", 64'(stall), 64'd0);
        tick();
        check_s("rst_all_zero", dut_q, idex_t'('0));
        check("rst_after_stall", 64'(stall), 64'd0);
        reset_n = 1'b1;
        drive(1'b1, 64'h38, enc_r(7'd0, 5'd5, 5'd3, 3'b000, 5'd10));
        tick();
        check("rst_reg_clear", ex_rdata1, 64'd0);

        for (int n = 0; n < 3000; n++) begin
            if (!last_stall) begin
                if_valid = ($urandom_range(0, 4) != 0);
                if_pc    = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0
                                                        : {$urandom, $urandom};
                if_instr = rand_instr();
            end
            flush   = ($urandom_range(0, 9) == 0);
            wb_we   = 1'($urandom_range(0, 1));
            wb_addr = 5'($urandom_range(0, 7));
            wb_data = {$urandom, $urandom};
            reset_n = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL take parameter XLEN, default 64, as the datapath width; legal values are 32 and 64.
REQ-002 SHALL take parameter NREGS, default 32, as the register count; rs/rd index width is $clog2(NREGS).
REQ-003 SHALL have these ports, in this order:
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- if_valid  in  1  the IF/ID instruction is valid.
- if_pc  in  XLEN  instruction PC.
- if_instr  in  32  instruction word.
- wb_we  in  1  writeback enable.
- wb_addr  in  5  writeback register index.
- wb_data  in  XLEN  writeback data.
- flush  in  1  squash the instruction in ID (branch resolved in EX).
- stall  out  1  hold IF/PC this cycle.
- ex_valid  out  1  the ID/EX register holds a real instruction.
- ex_pc, ex_rdata1, ex_rdata2, ex_imm, ex_target  out  XLEN  registered operands, immediate, and pc+imm.
- ex_rs1, ex_rs2, ex_rd  out  5  registered register indices.
- ex_funct3  out  3  registered funct3.
- ex_ctrl_wb  out  2  {MemtoReg, RegWrite}.
- ex_ctrl_m  out  2  {MemRead, MemWrite}.
- ex_ctrl_ex  out  4  {ALUSrc, ALUOp[2:0]}.
- ex_br, ex_jal, ex_jalr, ex_illegal  out  1  registered instruction-class flags.

Function
REQ-004 SHALL decode these opcodes: R 0110011, ADDI 0010011, LD 0000011, JALR 1100111, SD 0100011, B 1100011, JAL 1101111.
REQ-005 SHALL sign-extend the immediate to XLEN by instruction type:
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- R: 0.
REQ-006 SHALL use this ALUOp encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLL, 101 SLT.
REQ-007 SHALL decode R-type as: f3=000 with f7[5]=0 → ADD; f3=000 with f7[5]=1 → SUB; f3=001 → SLL; f3=010 → SLT; f3=111 → AND; f3=110 → OR.
REQ-008 SHALL use these control words {wb,m,ex}:
- ADDI 01_00_1000
- LD 11_10_1000
- SD 00_01_1000
- R 01_00_0ooo
- B 00_00_0001
- JAL/JALR 01_00_0000
REQ-009 SHALL treat any other opcode, or any other R-type funct combination, as illegal: all-zero control with ex_illegal=1.
REQ-010 SHALL implement an NREGS x XLEN register file; x0 reads 0 and is never written.
REQ-011 SHALL write the register file at posedge when wb_we=1 and wb_addr≠0.
REQ-012 SHALL bypass writeback to reads in the same cycle: when wb_we=1 and wb_addr equals rs (rs≠0), the read returns wb_data.
REQ-013 SHALL use rs2 only for R, S and B; SHALL use rs1 for all types except JAL.
REQ-014 SHALL drive stall combinationally (0-cycle latency) high when all hold: if_valid, ex_valid, ex_ctrl_m[1], ex_rd≠0, and ex_rd equals a used rs1/rs2.
REQ-015 SHALL have 1-cycle ID/EX latency: at posedge with no stall and no flush, it captures decode results with ex_valid=if_valid.
REQ-016 SHALL load a bubble during stall: ex_valid=0, all ctrl and flags 0, remaining fields don't-care but held at 0; IF holds its instruction, so it re-decodes next cycle.
REQ-017 SHALL give flush priority over stall: on flush it loads a bubble and forces stall=0.
REQ-018 SHALL load a bubble when if_valid=0.
REQ-019 SHALL compute ex_target as if_pc + imm modulo 2^XLEN, wrapping silently.

Reset
REQ-020 SHALL, when reset_n=0 at posedge, clear every register-file entry and every ID/EX output to 0, taking priority over wb_we.
REQ-021 SHALL drive stall=0 whenever ex_valid=0, including during and immediately after reset.

Structure
REQ-022 SHALL place in shared package decode_pkg: the opcode constants, the ALUOp enum, the ctrl field widths, and the control-word constants.
REQ-023 SHALL put the register file in sub-module reg_file (parameters XLEN, NREGS; 2 read ports, 1 write port, bypass included).

Verification
REQ-024 Bench SHALL cover: ADDI x5,x0,-1 (XLEN=64) → next cycle ex_imm=FFFF_FFFF_FFFF_FFFF, ex_ctrl_ex=1000, ex_ctrl_wb=01.
REQ-025 Bench SHALL cover: LD x6,0(x1), then ADD x7,x6,x2 → stall=1 for one cycle, one bubble (ex_valid=0), then the ADD issues.
REQ-026 Bench SHALL cover: wb_we=1, wb_addr=3, wb_data=0x1234 with ADD reading x3 in the same cycle → ex_rdata1=0x1234.
REQ-027 Bench SHALL cover: write to x0 with 0xDEAD, then read x0 → 0.
REQ-028 Bench SHALL cover: BEQ with offset -8 at pc 0x100 → ex_target=0xF8, ex_br=1; with flush=1 in the same cycle → ex_valid=0.
REQ-029 Bench SHALL cover: reset_n=0 during a load-use stall → next cycle all outputs 0, stall=0, registers read 0.
